// File: rtl/maze_link_rx_pkg.sv
// Shared constants and types for the maze tile serial receiver.
package maze_link_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_OVF  = 5'd17;

  localparam int unsigned MARKER_BIT = 15;
  localparam int unsigned ROW_MSB    = 14;
  localparam int unsigned ROW_LSB    = 12;
  localparam int unsigned COL_MSB    = 11;
  localparam int unsigned COL_LSB    = 9;
  localparam int unsigned PARITY_BIT = 8;
  localparam int unsigned TILE_MSB   = 7;
  localparam int unsigned TILE_LSB   = 0;

  localparam logic [2:0] CLEAR_CODE = 3'd7;

  // Tile byte layout as interpreted by the VGA colour logic.
  localparam int unsigned WALL_MSB     = 7;
  localparam int unsigned WALL_LSB     = 4;
  localparam int unsigned TREASURE_BIT = 3;
  localparam int unsigned TCOLOUR_MSB  = 2;
  localparam int unsigned TCOLOUR_LSB  = 1;
  localparam int unsigned ROBOT_BIT    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    EVAL = 2'd2
  } state_e;

endpackage

// File: rtl/maze_link_rx_if.sv
// Serial link pins plus the tile read port and status outputs.
interface maze_link_rx_if #(
  parameter int unsigned ERR_W = 8
);
  logic             SCLK;
  logic             SDATA;
  logic             SFRAME;
  logic [2:0]       RD_ROW;
  logic [2:0]       RD_COL;
  logic [7:0]       RD_DATA;
  logic             FRAME_OK;
  logic             FRAME_ERR;
  logic [ERR_W-1:0] ERR_COUNT;

  modport master (
    output SCLK, SDATA, SFRAME, RD_ROW, RD_COL,
    input  RD_DATA, FRAME_OK, FRAME_ERR, ERR_COUNT
  );

  modport slave (
    input  SCLK, SDATA, SFRAME, RD_ROW, RD_COL,
    output RD_DATA, FRAME_OK, FRAME_ERR, ERR_COUNT
  );
endinterface

// File: rtl/maze_link_rx_sync_edge.sv
// Two-flop synchronizer with a registered previous value for edge detection.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = async_i;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;
  assign fall_o  = ~s2_q & prev_q;
endmodule

// File: rtl/maze_link_rx.sv
// Receives 16-bit tile update frames over SCLK/SDATA/SFRAME into a ROWSxCOLS tile file.
module maze_link_rx
  import maze_link_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 5,
  parameter int unsigned ERR_W = 8
) (
  input  logic CLOCK,
  input  logic RESET_N,
  maze_link_rx_if.slave link
);
  logic sclk_level_unused, sclk_rise, sclk_fall_unused;
  logic sframe_level_unused, sframe_rise, sframe_fall;
  logic sdata, sdata_rise_unused, sdata_fall_unused;

  sync_edge u_sync_sclk (
    .clk(CLOCK), .rst_n(RESET_N), .async_i(link.SCLK),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  sync_edge u_sync_sframe (
    .clk(CLOCK), .rst_n(RESET_N), .async_i(link.SFRAME),
    .level_o(sframe_level_unused), .rise_o(sframe_rise), .fall_o(sframe_fall)
  );

  sync_edge u_sync_sdata (
    .clk(CLOCK), .rst_n(RESET_N), .async_i(link.SDATA),
    .level_o(sdata), .rise_o(sdata_rise_unused), .fall_o(sdata_fall_unused)
  );

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ok_q, ok_d;
  logic                    err_q, err_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [7:0]              grid_q [ROWS][COLS];
  logic [7:0]              grid_d [ROWS][COLS];

  logic [2:0] f_row, f_col;
  logic [7:0] f_tile;
  logic       f_clear, f_in_range, f_accept;

  assign f_row      = shift_q[ROW_MSB:ROW_LSB];
  assign f_col      = shift_q[COL_MSB:COL_LSB];
  assign f_tile     = shift_q[TILE_MSB:TILE_LSB];
  assign f_clear    = (f_row == CLEAR_CODE) && (f_col == CLEAR_CODE);
  assign f_in_range = (32'(f_row) < ROWS) && (32'(f_col) < COLS);
  assign f_accept   = (cnt_q == CNT_FULL) && shift_q[MARKER_BIT]
                      && !(^shift_q) && (f_in_range || f_clear);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    grid_d    = grid_q;

    unique case (state_q)
      IDLE, RECV: begin
        // A frame start takes a coincident SCLK rise as its first bit; a fall
        // ends the frame and discards any coincident SCLK rise.
        if (state_q == RECV && sframe_fall) begin
          state_d = EVAL;
        end else if (sframe_rise) begin
          state_d = RECV;
          shift_d = '0;
          cnt_d   = '0;
          if (sclk_rise) begin
            shift_d = {{(FRAME_BITS-1){1'b0}}, sdata};
            cnt_d   = 5'd1;
          end
        end else if (state_q == RECV && sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdata};
          cnt_d   = (cnt_q == CNT_OVF) ? CNT_OVF : cnt_q + 5'd1;
        end
      end
      EVAL: begin
        state_d = IDLE;
        if (f_accept) begin
          ok_d = 1'b1;
          for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
              if (f_clear) begin
                grid_d[r][c] = '0;
              end else if (f_row == r[2:0] && f_col == c[2:0]) begin
                grid_d[r][c] = f_tile;
              end
            end
          end
        end else begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          grid_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      grid_q    <= grid_d;
    end
  end

  always_comb begin
    link.RD_DATA = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (link.RD_ROW == r[2:0] && link.RD_COL == c[2:0]) begin
          link.RD_DATA = grid_q[r][c];
        end
      end
    end
  end

  assign link.FRAME_OK  = ok_q;
  assign link.FRAME_ERR = err_q;
  assign link.ERR_COUNT = err_cnt_q;
endmodule

// File: tb/tb_maze_link_rx.sv
// Directed bench for maze_link_rx: frame accept/reject, clear code, saturation, reset.
module tb_maze_link_rx;
  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  maze_link_rx_if #(.ERR_W(8)) link ();

  maze_link_rx #(.ROWS(4), .COLS(5), .ERR_W(8)) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .link(link.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] make_frame(input logic [2:0] r, input logic [2:0] c,
                                             input logic [7:0] t);
    logic [15:0] f;
    f    = {1'b1, r, c, 1'b0, t};
    f[8] = ^f;
    return f;
  endfunction

  task automatic rd(input int r, input int c, output logic [7:0] d);
    logic [2:0] rr, cc;
    rr = r[2:0];
    cc = c[2:0];
    link.RD_ROW = rr;
    link.RD_COL = cc;
    #1;
    d = link.RD_DATA;
  endtask

  task automatic count_nonzero(output int n);
    logic [7:0] d;
    n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        rd(r, c, d);
        if (d !== 8'h00) n++;
      end
  endtask

  // Watches 20 cycles after SFRAME drops; idx is the first negedge with a pulse.
  task automatic collect(output int n_ok, output int n_err, output int idx,
                         output logic [7:0] rd_pre);
    n_ok = 0; n_err = 0; idx = 0; rd_pre = 8'hxx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) rd_pre = link.RD_DATA;
      if (link.FRAME_OK === 1'b1) n_ok++;
      if (link.FRAME_ERR === 1'b1) n_err++;
      if (idx == 0 && (link.FRAME_OK === 1'b1 || link.FRAME_ERR === 1'b1)) idx = k;
    end
  endtask

  task automatic send_frame(input logic [31:0] data, input int n, input bit coincide,
                            output int n_ok, output int n_err, output int idx,
                            output logic [7:0] rd_pre);
    @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      link.SDATA = data[i];
      if (i == n - 1 && coincide) begin
        link.SFRAME = 1'b1;
        link.SCLK   = 1'b1;
        repeat (6) @(negedge clk);
        link.SCLK = 1'b0;
        repeat (6) @(negedge clk);
      end else begin
        if (i == n - 1) begin
          link.SFRAME = 1'b1;
          repeat (6) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        link.SCLK = 1'b1;
        repeat (6) @(negedge clk);
        link.SCLK = 1'b0;
      end
    end
    repeat (6) @(negedge clk);
    link.SFRAME = 1'b0;
    collect(n_ok, n_err, idx, rd_pre);
  endtask

  task automatic test_reset;
    int nz;
    rst_n = 1'b0;
    link.SCLK = 1'b0; link.SDATA = 1'b0; link.SFRAME = 1'b0;
    link.RD_ROW = 3'd0; link.RD_COL = 3'd0;
    repeat (3) @(negedge clk);
    total_cnt++; if (link.FRAME_OK !== 1'b0) $display("FAIL reset_ok got %b exp 0", link.FRAME_OK); else pass_cnt++;
    total_cnt++; if (link.FRAME_ERR !== 1'b0) $display("FAIL reset_err got %b exp 0", link.FRAME_ERR); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd0) $display("FAIL reset_errcnt got %0d exp 0", link.ERR_COUNT); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 0) $display("FAIL reset_grid nonzero got %0d exp 0", nz); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_accept;
    int ok, er, idx, nz;
    logic [7:0] pre, d;
    link.RD_ROW = 3'd2; link.RD_COL = 3'd3;
    send_frame(32'h0000A6A5, 16, 1'b0, ok, er, idx, pre);
    total_cnt++; if (ok !== 1) $display("FAIL accept_ok_pulses got %0d exp 1", ok); else pass_cnt++;
    total_cnt++; if (er !== 0) $display("FAIL accept_err_pulses got %0d exp 0", er); else pass_cnt++;
    total_cnt++; if (idx !== 4) $display("FAIL accept_latency got %0d exp 4", idx); else pass_cnt++;
    total_cnt++; if (pre !== 8'h00) $display("FAIL accept_old_before_write got %h exp 00", pre); else pass_cnt++;
    rd(2, 3, d);
    total_cnt++; if (d !== 8'hA5) $display("FAIL accept_tile got %h exp a5", d); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 1) $display("FAIL accept_others got %0d nonzero exp 1", nz); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd0) $display("FAIL accept_errcnt got %0d exp 0", link.ERR_COUNT); else pass_cnt++;
  endtask

  task automatic test_parity;
    int ok, er, idx;
    logic [7:0] pre, d;
    send_frame(32'h0000A7A5, 16, 1'b0, ok, er, idx, pre);
    total_cnt++; if (er !== 1) $display("FAIL parity_err_pulses got %0d exp 1", er); else pass_cnt++;
    total_cnt++; if (ok !== 0) $display("FAIL parity_ok_pulses got %0d exp 0", ok); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd1) $display("FAIL parity_errcnt got %0d exp 1", link.ERR_COUNT); else pass_cnt++;
    rd(2, 3, d);
    total_cnt++; if (d !== 8'hA5) $display("FAIL parity_tile got %h exp a5", d); else pass_cnt++;
  endtask

  task automatic test_range;
    int ok, er, idx, nz;
    logic [7:0] pre;
    send_frame(32'h00008B00, 16, 1'b0, ok, er, idx, pre);
    total_cnt++; if (er !== 1 || ok !== 0) $display("FAIL range_pulses got ok=%0d err=%0d exp ok=0 err=1", ok, er); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd2) $display("FAIL range_errcnt got %0d exp 2", link.ERR_COUNT); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 1) $display("FAIL range_grid got %0d nonzero exp 1", nz); else pass_cnt++;
  endtask

  task automatic test_length;
    int ok, er, idx;
    logic [7:0] pre;
    send_frame(32'h0000A6A5 >> 1, 15, 1'b0, ok, er, idx, pre);
    total_cnt++; if (er !== 1 || ok !== 0) $display("FAIL short_pulses got ok=%0d err=%0d exp ok=0 err=1", ok, er); else pass_cnt++;
    send_frame(32'h0000A6A5 << 1, 17, 1'b0, ok, er, idx, pre);
    total_cnt++; if (er !== 1 || ok !== 0) $display("FAIL long_pulses got ok=%0d err=%0d exp ok=0 err=1", ok, er); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd4) $display("FAIL length_errcnt got %0d exp 4", link.ERR_COUNT); else pass_cnt++;
  endtask

  task automatic test_clear;
    int ok, er, idx, nz;
    logic [7:0] pre, d;
    send_frame({16'h0, make_frame(3'd0, 3'd0, 8'h11)}, 16, 1'b0, ok, er, idx, pre);
    total_cnt++; if (ok !== 1) $display("FAIL fill00_ok got %0d exp 1", ok); else pass_cnt++;
    send_frame({16'h0, make_frame(3'd3, 3'd4, 8'h22)}, 16, 1'b0, ok, er, idx, pre);
    rd(3, 4, d);
    total_cnt++; if (d !== 8'h22) $display("FAIL fill34_tile got %h exp 22", d); else pass_cnt++;
    rd(4, 0, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL oor_row_read got %h exp 00", d); else pass_cnt++;
    rd(0, 5, d);
    total_cnt++; if (d !== 8'h00) $display("FAIL oor_col_read got %h exp 00", d); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 3) $display("FAIL fill_count got %0d exp 3", nz); else pass_cnt++;
    send_frame(32'h0000FF00, 16, 1'b0, ok, er, idx, pre);
    total_cnt++; if (ok !== 1 || er !== 0) $display("FAIL clear_pulses got ok=%0d err=%0d exp ok=1 err=0", ok, er); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 0) $display("FAIL clear_grid got %0d nonzero exp 0", nz); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd4) $display("FAIL clear_errcnt got %0d exp 4", link.ERR_COUNT); else pass_cnt++;
  endtask

  task automatic test_coincide_start;
    int ok, er, idx;
    logic [7:0] pre, d;
    send_frame({16'h0, make_frame(3'd1, 3'd1, 8'h3C)}, 16, 1'b1, ok, er, idx, pre);
    total_cnt++; if (ok !== 1 || er !== 0) $display("FAIL coincide_pulses got ok=%0d err=%0d exp ok=1 err=0", ok, er); else pass_cnt++;
    rd(1, 1, d);
    total_cnt++; if (d !== 8'h3C) $display("FAIL coincide_tile got %h exp 3c", d); else pass_cnt++;
  endtask

  task automatic test_saturate;
    int ok, er, idx, errs;
    logic [7:0] pre;
    errs = 0;
    for (int i = 0; i < 260; i++) begin
      send_frame(32'h1, 1, 1'b0, ok, er, idx, pre);
      errs += er;
    end
    total_cnt++; if (errs !== 260) $display("FAIL sat_err_pulses got %0d exp 260", errs); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd255) $display("FAIL sat_errcnt got %0d exp 255", link.ERR_COUNT); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame;
    int ok, er, idx, nz;
    logic [7:0] pre;
    @(negedge clk);
    link.SFRAME = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      link.SDATA = i[0];
      repeat (6) @(negedge clk);
      link.SCLK = 1'b1;
      repeat (6) @(negedge clk);
      link.SCLK = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (link.FRAME_OK !== 1'b0 || link.FRAME_ERR !== 1'b0) $display("FAIL midrst_pulses got ok=%b err=%b exp 0 0", link.FRAME_OK, link.FRAME_ERR); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd0) $display("FAIL midrst_errcnt got %0d exp 0", link.ERR_COUNT); else pass_cnt++;
    count_nonzero(nz);
    total_cnt++; if (nz !== 0) $display("FAIL midrst_grid got %0d nonzero exp 0", nz); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    link.SFRAME = 1'b0;
    collect(ok, er, idx, pre);
    total_cnt++; if (er !== 1 || ok !== 0) $display("FAIL partial_pulses got ok=%0d err=%0d exp ok=0 err=1", ok, er); else pass_cnt++;
    total_cnt++; if (link.ERR_COUNT !== 8'd1) $display("FAIL partial_errcnt got %0d exp 1", link.ERR_COUNT); else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_accept();
    test_parity();
    test_range();
    test_length();
    test_clear();
    test_coincide_start();
    test_saturate();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
